// File: rtl/nrs_cinit_seq.sv
// NB-IoT NRS c_init sequencer: four seeds per subframe through one shared multiplier.
// Optional input range check (err port) is enabled by defining NRS_RANGE_CHK_EN.

module nrs_cinit_mult #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 10
) (
  input  logic [WIDTH_A-1:0]         i_a,
  input  logic [WIDTH_B-1:0]         i_b,
  output logic [WIDTH_A+WIDTH_B-1:0] o_p
);
  assign o_p = {{WIDTH_B{1'b0}}, i_a} * {{WIDTH_A{1'b0}}, i_b};
endmodule

module nrs_cinit_seq #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 10,
  parameter int CINIT_W = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         subframe,
  input  logic [8:0]         n_id_ncell,
  input  logic               cinit_ready,
  output logic               busy,
  output logic               cinit_valid,
  output logic [CINIT_W-1:0] cinit,
  output logic [4:0]         slot_idx,
  output logic [2:0]         sym_idx,
  output logic               done
`ifdef NRS_RANGE_CHK_EN
  , output logic             err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_MULT = 3'd2,
    S_OUT  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [3:0]                 r_sf;
  logic [8:0]                 r_nid;
  logic [1:0]                 r_idx;
  logic [WIDTH_A-1:0]         r_a;
  logic [WIDTH_B-1:0]         r_b;
  logic [4:0]                 r_ns;
  logic [2:0]                 r_l;

  logic                       r_busy;
  logic                       r_valid;
  logic [CINIT_W-1:0]         r_cinit;
  logic [4:0]                 r_slot;
  logic [2:0]                 r_sym;
  logic                       r_done;

  logic                       w_accept;
  logic [4:0]                 w_ns;
  logic [2:0]                 w_l;
  logic [WIDTH_A-1:0]         w_ns1;
  logic [WIDTH_A-1:0]         w_a;
  logic [WIDTH_A+WIDTH_B-1:0] w_prod;
  logic [CINIT_W-1:0]         w_cinit_nxt;
  logic                       w_busy_nxt;
  logic                       w_valid_nxt;
  logic                       w_done_nxt;
  logic                       w_load_out;

`ifdef NRS_RANGE_CHK_EN
  logic r_err;
  logic w_range_bad;
  logic w_err_nxt;
  assign w_range_bad = (subframe > 4'd9) || (n_id_ncell > 9'd503);
  assign w_accept    = start && !w_range_bad;
  assign err         = r_err;
`else
  assign w_accept    = start;
`endif

  // A = 7*(ns+1) + l + 1, with the x7 done as a shift and subtract
  assign w_ns        = {r_sf, r_idx[1]};
  assign w_l         = r_idx[0] ? 3'd6 : 3'd5;
  assign w_ns1       = WIDTH_A'(w_ns) + WIDTH_A'(1'b1);
  assign w_a         = (w_ns1 << 3'd3) - w_ns1 + WIDTH_A'(w_l) + WIDTH_A'(1'b1);
  assign w_cinit_nxt = CINIT_W'({w_prod, 10'd0}) + CINIT_W'(r_b);

  nrs_cinit_mult #(
    .WIDTH_A (WIDTH_A),
    .WIDTH_B (WIDTH_B)
  ) u_mult (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_accept ? S_CALC : S_IDLE;
      S_CALC:  w_state_nxt = S_MULT;
      S_MULT:  w_state_nxt = S_OUT;
      S_OUT: begin
        if (cinit_ready) w_state_nxt = (r_idx == 2'd3) ? S_DONE : S_CALC;
        else             w_state_nxt = S_OUT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state
  always_comb begin
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_valid_nxt = (w_state_nxt == S_OUT);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_load_out  = (r_state == S_MULT);
`ifdef NRS_RANGE_CHK_EN
    w_err_nxt   = (r_state == S_IDLE) && start && w_range_bad;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cinit <= {CINIT_W{1'b0}};
      r_slot  <= 5'd0;
      r_sym   <= 3'd0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_load_out) begin
        r_cinit <= w_cinit_nxt;
        r_slot  <= r_ns;
        r_sym   <= r_l;
      end
    end
  end

`ifdef NRS_RANGE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sf  <= 4'd0;
      r_nid <= 9'd0;
      r_idx <= 2'd0;
      r_a   <= {WIDTH_A{1'b0}};
      r_b   <= {WIDTH_B{1'b0}};
      r_ns  <= 5'd0;
      r_l   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sf  <= subframe;
            r_nid <= n_id_ncell;
            r_idx <= 2'd0;
          end
        end
        S_CALC: begin
          r_a  <= w_a;
          r_b  <= WIDTH_B'({r_nid, 1'b1});
          r_ns <= w_ns;
          r_l  <= w_l;
        end
        S_OUT: begin
          if (cinit_ready && (r_idx != 2'd3)) r_idx <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = r_busy;
  assign cinit_valid = r_valid;
  assign cinit       = r_cinit;
  assign slot_idx    = r_slot;
  assign sym_idx     = r_sym;
  assign done        = r_done;

endmodule

// File: tb/tb_nrs_cinit_seq.sv
// Scoreboard bench for nrs_cinit_seq; expected seeds come from the closed-form c_init formula.
module tb_nrs_cinit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  subframe;
  logic [8:0]  n_id_ncell;
  logic        cinit_ready;
  logic        busy;
  logic        cinit_valid;
  logic [30:0] cinit;
  logic [4:0]  slot_idx;
  logic [2:0]  sym_idx;
  logic        done;
`ifdef NRS_RANGE_CHK_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [30:0] c;
    logic [4:0]  ns;
    logic [2:0]  l;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  nrs_cinit_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .subframe    (subframe),
    .n_id_ncell  (n_id_ncell),
    .cinit_ready (cinit_ready),
    .busy        (busy),
    .cinit_valid (cinit_valid),
    .cinit       (cinit),
    .slot_idx    (slot_idx),
    .sym_idx     (sym_idx),
    .done        (done)
`ifdef NRS_RANGE_CHK_EN
    , .err       (err)
`endif
  );

  task automatic push_expected(input int sf, input int nid);
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      int ns;
      int l;
      int b;
      ns   = 2 * sf + i / 2;
      l    = 5 + i % 2;
      b    = 2 * nid + 1;
      e.c  = 31'(1024 * (7 * (ns + 1) + l + 1) * b + b);
      e.ns = 5'(ns);
      e.l  = 3'(l);
      q.push_back(e);
    end
  endtask

  // Leaves the caller at the first falling edge after the start was accepted.
  task automatic start_req(input int sf, input int nid);
    @(negedge clk);
    subframe   = 4'(sf);
    n_id_ncell = 9'(nid);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; subframe = 4'd0; n_id_ncell = 9'd0; cinit_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, cinit_valid, cinit, slot_idx, sym_idx, done} !== 42'd0)
      $display("FAIL reset_outputs: got %h expected 0", {busy, cinit_valid, cinit, slot_idx, sym_idx, done});
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_sequence;
    int first_v = 0;
    int done_c  = 0;
    int n_done  = 0;
    exp_t e;
    cinit_ready = 1'b1;
    push_expected(0, 0);
    start_req(0, 0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL seq_busy: got %b expected 1", busy);
    else n_pass++;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (cinit_valid) begin
        if (first_v == 0) first_v = c;
        n_checks++;
        if (q.size() == 0) $display("FAIL seq_extra: got cinit %0d expected no output", cinit);
        else begin
          e = q.pop_front();
          if ({cinit, slot_idx, sym_idx} !== {e.c, e.ns, e.l})
            $display("FAIL seq_seed: got %0d (%0d,%0d) expected %0d (%0d,%0d)", cinit, slot_idx, sym_idx, e.c, e.ns, e.l);
          else n_pass++;
        end
      end
      if (done) begin n_done++; done_c = c; end
    end
    n_checks++;
    if (first_v != 3) $display("FAIL seq_first_valid: got cycle %0d expected 3", first_v);
    else n_pass++;
    n_checks++;
    if (done_c != 13 || n_done != 1) $display("FAIL seq_done: got cycle %0d count %0d expected cycle 13 count 1", done_c, n_done);
    else n_pass++;
    n_checks++;
    if (q.size() != 0) $display("FAIL seq_missing: got %0d seeds left expected 0", q.size());
    else n_pass++;
    q.delete();
  endtask

  task automatic test_max_seed;
    exp_t e;
    cinit_ready = 1'b1;
    push_expected(9, 503);
    start_req(9, 503);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (cinit_valid) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL max_extra: got cinit %0d expected no output", cinit);
        else begin
          e = q.pop_front();
          if ({cinit, slot_idx, sym_idx} !== {e.c, e.ns, e.l})
            $display("FAIL max_seed: got %0d (%0d,%0d) expected %0d (%0d,%0d)", cinit, slot_idx, sym_idx, e.c, e.ns, e.l);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL max_missing: got %0d seeds left expected 0", q.size());
    else n_pass++;
    q.delete();
  endtask

  task automatic test_backpressure;
    exp_t e;
    int   w = 0;
    int   n_done = 0;
    cinit_ready = 1'b0;
    push_expected(0, 1);
    start_req(0, 1);
    while (!cinit_valid && w < 10) begin @(negedge clk); w++; end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (cinit_valid !== 1'b1 || cinit !== q[0].c)
        $display("FAIL bp_hold: got valid %b cinit %0d expected valid 1 cinit %0d", cinit_valid, cinit, q[0].c);
      else n_pass++;
      @(negedge clk);
    end
    cinit_ready = 1'b1;
    e = q.pop_front();
    n_checks++;
    if (cinit_valid !== 1'b1 || cinit !== e.c)
      $display("FAIL bp_release: got valid %b cinit %0d expected valid 1 cinit %0d", cinit_valid, cinit, e.c);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cinit_valid !== 1'b0) $display("FAIL bp_gap1: got valid %b expected 0", cinit_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cinit_valid !== 1'b0) $display("FAIL bp_gap2: got valid %b expected 0", cinit_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cinit_valid !== 1'b1) $display("FAIL bp_next_valid: got valid %b expected 1", cinit_valid);
    else n_pass++;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (cinit_valid && q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if ({cinit, slot_idx, sym_idx} !== {e.c, e.ns, e.l})
          $display("FAIL bp_seed: got %0d (%0d,%0d) expected %0d (%0d,%0d)", cinit, slot_idx, sym_idx, e.c, e.ns, e.l);
        else n_pass++;
      end
      if (done) n_done++;
    end
    n_checks++;
    if (q.size() != 0 || n_done != 1) $display("FAIL bp_finish: got %0d left done %0d expected 0 left done 1", q.size(), n_done);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_start_ignored;
    exp_t e;
    int   n_done = 0;
    bit   seen_done = 1'b0;
    cinit_ready = 1'b1;
    push_expected(3, 100);
    start_req(3, 100);
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (seen_done) begin
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || cinit_valid !== 1'b0)
          $display("FAIL ign_after_done: got busy %b valid %b expected 0 0", busy, cinit_valid);
        else n_pass++;
        break;
      end
      if (cinit_valid) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL ign_extra: got cinit %0d expected no output", cinit);
        else begin
          e = q.pop_front();
          if ({cinit, slot_idx, sym_idx} !== {e.c, e.ns, e.l})
            $display("FAIL ign_seed: got %0d (%0d,%0d) expected %0d (%0d,%0d)", cinit, slot_idx, sym_idx, e.c, e.ns, e.l);
          else n_pass++;
        end
      end
      if (done) begin n_done++; seen_done = 1'b1; end
      start      = 1'b1;
      subframe   = 4'($urandom_range(0, 9));
      n_id_ncell = 9'($urandom_range(0, 503));
    end
    start = 1'b0;
    n_checks++;
    if (q.size() != 0 || n_done != 1) $display("FAIL ign_finish: got %0d left done %0d expected 0 left done 1", q.size(), n_done);
    else n_pass++;
    q.delete();
  endtask

  task automatic test_reset_mid_out;
    int w = 0;
    int bad = 0;
    cinit_ready = 1'b0;
    start_req(5, 7);
    while (!cinit_valid && w < 10) begin @(negedge clk); w++; end
    n_checks++;
    if (cinit_valid !== 1'b1) $display("FAIL rmo_reach_out: got valid %b expected 1", cinit_valid);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, cinit_valid, cinit, slot_idx, sym_idx, done} !== 42'd0)
      $display("FAIL rmo_async_clear: got %h expected 0", {busy, cinit_valid, cinit, slot_idx, sym_idx, done});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    cinit_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || cinit_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL rmo_after_release: got %0d active cycles expected 0", bad);
    else n_pass++;
  endtask

`ifdef NRS_RANGE_CHK_EN
  task automatic test_range_check;
    exp_t e;
    @(negedge clk);
    subframe = 4'd0; n_id_ncell = 9'd504; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cinit_valid !== 1'b0)
      $display("FAIL rng_reject: got err %b busy %b valid %b expected 1 0 0", err, busy, cinit_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0) $display("FAIL rng_pulse: got err %b busy %b expected 0 0", err, busy);
    else n_pass++;
    cinit_ready = 1'b1;
    push_expected(2, 503);
    start_req(2, 503);
    n_checks++;
    if (busy !== 1'b1 || err !== 1'b0) $display("FAIL rng_accept: got busy %b err %b expected 1 0", busy, err);
    else n_pass++;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) @(negedge clk);
      if (cinit_valid && q.size() != 0) begin
        e = q.pop_front();
        n_checks++;
        if ({cinit, slot_idx, sym_idx} !== {e.c, e.ns, e.l})
          $display("FAIL rng_seed: got %0d (%0d,%0d) expected %0d (%0d,%0d)", cinit, slot_idx, sym_idx, e.c, e.ns, e.l);
        else n_pass++;
      end
    end
    n_checks++;
    if (q.size() != 0) $display("FAIL rng_missing: got %0d seeds left expected 0", q.size());
    else n_pass++;
    q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_max_seed();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_out();
`ifdef NRS_RANGE_CHK_EN
    test_range_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
